// File: rtl/rom_read_arbiter.sv
// Burst-read arbiter that shares one registered-output ROM between two requesters and returns tagged beats.
// Define ROM_ARB_FIXED_PRIO_EN to make requester 0 always win ties; the round-robin pointer is then removed.
module rom_read_arbiter #(
  parameter int AW = 4,
  parameter int DW = 4,
  parameter int LW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [LW-1:0] len0,
  input  logic [LW-1:0] len1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rom_en,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_id,
  output logic          rsp_last,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t        state, state_next;
  logic [AW-1:0] cur, sel_addr, rom_addr_next;
  logic [LW-1:0] cnt, sel_len;
  logic          burst_id, grant, beat_last;
  logic          gnt0_next, gnt1_next, rom_en_next, busy_next;
  logic          cap_valid, cap_last, cap_id;

  assign grant     = gnt0_next | gnt1_next;
  assign sel_addr  = gnt1_next ? addr1 : addr0;
  assign sel_len   = gnt1_next ? len1 : len0;
  assign beat_last = (state == READ) && (cnt == '0);

`ifndef ROM_ARB_FIXED_PRIO_EN
  logic last_served;

  always_ff @(posedge clk) begin
    if (!rst_n)     last_served <= 1'b1;
    else if (grant) last_served <= gnt1_next;
  end
`endif

  // NOTE: every comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    gnt0_next = 1'b0;
    gnt1_next = 1'b0;
    if (state == IDLE) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
      gnt0_next = req0;
`else
      gnt0_next = req0 && (!req1 || last_served);
`endif
      gnt1_next = req1 && !gnt0_next;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (grant) state_next = READ;
      READ:    if (beat_last) state_next = DRAIN;
      DRAIN:   if (rsp_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // rom_addr holds its last value outside READ so the ROM pins stay quiet while draining.
  always_comb begin
    rom_en_next   = (state_next == READ);
    busy_next     = (state_next != IDLE);
    rom_addr_next = rom_addr;
    if (grant)                            rom_addr_next = sel_addr;
    else if (state == READ && !beat_last) rom_addr_next = cur;
  end

  // NOTE: the synchronous reset also clears the capture pipeline, so beats in flight are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rom_en    <= 1'b0;
      rom_addr  <= '0;
      busy      <= 1'b0;
      cur       <= '0;
      cnt       <= '0;
      burst_id  <= 1'b0;
      cap_valid <= 1'b0;
      cap_last  <= 1'b0;
      cap_id    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      rsp_last  <= 1'b0;
    end else begin
      gnt0     <= gnt0_next;
      gnt1     <= gnt1_next;
      rom_en   <= rom_en_next;
      rom_addr <= rom_addr_next;
      busy     <= busy_next;
      if (grant) begin
        cur      <= sel_addr + AW'(1);
        cnt      <= sel_len;
        burst_id <= gnt1_next;
      end else if (state == READ && !beat_last) begin
        cur <= cur + AW'(1);
        cnt <= cnt - LW'(1);
      end
      // ROM data is valid the cycle after rom_en was sampled; register it once more onto rsp_*.
      cap_valid <= rom_en;
      cap_last  <= beat_last;
      cap_id    <= burst_id;
      rsp_valid <= cap_valid;
      rsp_data  <= cap_valid ? rom_data : '0;
      rsp_id    <= cap_valid & cap_id;
      rsp_last  <= cap_valid & cap_last;
    end
  end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Scoreboard bench for rom_read_arbiter: a burst-level model predicts grants, ROM reads and beats per cycle.
// Honours ROM_ARB_FIXED_PRIO_EN for the tie-break rule.
module tb_rom_read_arbiter;
  localparam int AW = 4;
  localparam int DW = 4;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          rst_n, req0, req1;
  logic [AW-1:0] addr0, addr1, rom_addr;
  logic [LW-1:0] len0, len1;
  logic          gnt0, gnt1, rom_en;
  logic [DW-1:0] rom_data, rsp_data;
  logic          rsp_valid, rsp_id, rsp_last, busy;

  rom_read_arbiter #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1), .len0(len0), .len1(len1),
    .gnt0(gnt0), .gnt1(gnt1), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_last(rsp_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // Bench ROM: registered output, en-gated, X whenever en was low.
  logic [DW-1:0] img [16];
  always @(posedge clk) rom_data <= rom_en ? img[rom_addr] : 'x;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic id; } gnt_t;
  typedef struct { int cyc; logic [AW-1:0] addr; } rom_t;
  typedef struct { int cyc; logic [DW-1:0] data; logic id; logic last; } rsp_t;

  gnt_t gq[$];
  rom_t rq[$];
  rsp_t sq[$];
  logic obs_g[$];

  int n_err = 0, n_chk = 0;
  int free_cyc = 1, busy_from = 1, busy_to = 0;
  bit ptr = 1'b1;
  bit granted[2];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  // Burst-level model: a granted burst of L words occupies the ROM for L cycles, beats follow 2 later.
  task automatic predict();
    if (!rst_n) begin
      gq.delete(); rq.delete(); sq.delete();
      free_cyc = cyc + 1; busy_from = 1; busy_to = 0; ptr = 1'b1;
      granted[0] = 1'b0; granted[1] = 1'b0;
    end else if (cyc >= free_cyc && (req0 || req1)) begin
      bit g;
      int n;
      logic [AW-1:0] a;
      if (req0 && req1) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
        g = 1'b0;
`else
        g = !ptr;
`endif
      end else begin
        g = req1;
      end
      a = g ? addr1 : addr0;
      n = int'(g ? len1 : len0) + 1;
      gq.push_back('{cyc + 1, g});
      for (int k = 0; k < n; k++) begin
        logic [AW-1:0] ak;
        ak = a + AW'(k);
        rq.push_back('{cyc + 1 + k, ak});
        sq.push_back('{cyc + 3 + k, img[ak], g, (k == n - 1)});
      end
      busy_from = cyc + 1; busy_to = cyc + n + 2; free_cyc = cyc + n + 3;
      ptr = g; granted[g] = 1'b1;
    end
  endtask

  task automatic step(bit r, bit q0, logic [AW-1:0] a0, logic [LW-1:0] l0,
                      bit q1, logic [AW-1:0] a1, logic [LW-1:0] l1);
    @(negedge clk); #1;
    rst_n = r; req0 = q0; addr0 = a0; len0 = l0; req1 = q1; addr1 = a1; len1 = l1;
    predict();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && cyc < free_cyc + 1; i++) step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic burst(bit id, logic [AW-1:0] a, logic [LW-1:0] l);
    granted[0] = 1'b0; granted[1] = 1'b0;
    for (int i = 0; i < 20 && !granted[id]; i++) step(1'b1, !id, a, l, id, a, l);
    wait_idle();
  endtask

  task automatic rand_step();
    bit            q [2];
    logic [AW-1:0] a [2];
    logic [LW-1:0] l [2];
    bit            r;
    q[0] = req0; q[1] = req1; a[0] = addr0; a[1] = addr1; l[0] = len0; l[1] = len1;
    for (int i = 0; i < 2; i++) begin
      if (granted[i]) begin
        granted[i] = 1'b0;
        q[i] = ($urandom_range(1, 0) == 1);
        a[i] = AW'($urandom); l[i] = LW'($urandom);
      end else if (!q[i]) begin
        if ($urandom_range(2, 0) == 0) begin
          q[i] = 1'b1; a[i] = AW'($urandom); l[i] = LW'($urandom);
        end
      end else if ($urandom_range(9, 0) == 0) begin
        q[i] = 1'b0;
      end else if ($urandom_range(3, 0) == 0) begin
        a[i] = AW'($urandom); l[i] = LW'($urandom);
      end
    end
    r = ($urandom_range(299, 0) != 0);
    step(r, q[0], a[0], l[0], q[1], a[1], l[1]);
  endtask

  // Monitor: every cycle compares the DUT against the head of each expectation queue.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      logic [1:0] eg;
      eg = 2'b00;
      if (gq.size() > 0 && gq[0].cyc == cyc) begin
        eg = gq[0].id ? 2'b10 : 2'b01;
        gq.delete(0);
      end
      check("gnt", 32'({gnt1, gnt0}), 32'(eg));
      if (gnt0 === 1'b1) obs_g.push_back(1'b0);
      if (gnt1 === 1'b1) obs_g.push_back(1'b1);
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        check("rom_en", 32'(rom_en), 1);
        check("rom_addr", 32'(rom_addr), 32'(rq[0].addr));
        rq.delete(0);
      end else begin
        check("rom_en_low", 32'(rom_en), 0);
      end
      if (sq.size() > 0 && sq[0].cyc == cyc) begin
        check("rsp_valid", 32'(rsp_valid), 1);
        check("rsp_data", 32'(rsp_data), 32'(sq[0].data));
        check("rsp_id", 32'(rsp_id), 32'(sq[0].id));
        check("rsp_last", 32'(rsp_last), 32'(sq[0].last));
        sq.delete(0);
      end else begin
        check("rsp_valid_low", 32'(rsp_valid), 0);
        check("rsp_data_zero", 32'(rsp_data), 0);
        check("rsp_last_low", 32'(rsp_last), 0);
      end
      check("busy", 32'(busy), 32'(cyc >= busy_from && cyc <= busy_to));
    end
  end

  initial begin
    logic          exp_order [3];
    logic [AW-1:0] ra0, ra1;
    int            ng;
    img = '{4'h2, 4'h2, 4'hE, 4'h2, 4'h4, 4'hA, 4'hC, 4'h0,
            4'hA, 4'h2, 4'hE, 4'h2, 4'h4, 4'hA, 4'hC, 4'h0};
`ifdef ROM_ARB_FIXED_PRIO_EN
    exp_order = '{1'b0, 1'b0, 1'b0};
`else
    exp_order = '{1'b0, 1'b1, 1'b0};
`endif
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
    addr0 = '0; addr1 = '0; len0 = '0; len1 = '0;

    // Reset held with both requests pending: nothing may be granted.
    step(1'b0, 1'b1, 4'd5, 2'd1, 1'b1, 4'd9, 2'd2);

    // Plain burst, then a burst that wraps 15 -> 0.
    burst(1'b0, 4'd2, 2'd3);
    burst(1'b1, 4'd14, 2'd3);

    // Both requesters held through three single-word bursts.
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    obs_g.delete();
    granted[0] = 1'b0; granted[1] = 1'b0;
    ng = 0;
    ra0 = AW'($urandom); ra1 = AW'($urandom);
    for (int i = 0; i < 40 && ng < 3; i++) begin
      step(1'b1, 1'b1, ra0, 2'd0, 1'b1, ra1, 2'd0);
      if (granted[0] || granted[1]) begin
        ng++;
        granted[0] = 1'b0; granted[1] = 1'b0;
      end
    end
    wait_idle();
    check("order_count", 32'(obs_g.size()), 3);
    for (int k = 0; k < 3 && k < obs_g.size(); k++)
      check("order", 32'(obs_g[k]), 32'(exp_order[k]));

    // Reset in the fourth cycle of a burst: in-flight beats vanish, no rsp_last.
    step(1'b1, 1'b1, 4'd2, 2'd3, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    wait_idle();

    // Randomized traffic with occasional resets.
    granted[0] = 1'b0; granted[1] = 1'b0;
    for (int i = 0; i < 2000; i++) rand_step();
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    wait_idle();
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);

    check("gnt_queue_empty", 32'(gq.size()), 0);
    check("rom_queue_empty", 32'(rq.size()), 0);
    check("rsp_queue_empty", 32'(sq.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
